cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run controller that sequences the pipelined RISC-V `cpu` top: host program/data load, CPU reset, a bounded run, halt, and memory readback. It owns the CPU's `enable` and both external memory ports (`*_ext` instruction memory, `*_ext_2` data memory). It exposes one valid/ready access channel and a start/stop run interface to the host or testbench. It sits directly above `cpu` and is the only driver of those pins.

## Interface
- `CYC_W`, 32, width of cycle limit and cycle counter
- `clk` in 1 — clock
- `arst` in 1 — asynchronous reset, active-high
- `start` in 1 — run request; accepted only in IDLE or DONE
- `stop` in 1 — halt request; honoured only in RUN
- `cycle_limit` in CYC_W — enabled-cycle budget, sampled when `start` is accepted; 0 = unlimited
- `busy` out 1 — high in RST and RUN
- `done` out 1 — high in DONE
- `cycles` out CYC_W — enabled cycles of current/last run, saturating
- `acc_valid` in 1, `acc_ready` out 1 — access handshake
- `acc_write` in 1 — 1 = write, 0 = read
- `acc_sel` in 1 — 0 = instruction memory, 1 = data memory
- `acc_addr` in 64, `acc_wdata` in 64 — imem writes use `[31:0]`
- `rsp_valid` out 1, `rsp_data` out 64 — read response; imem zero-extended
- `cpu_arst_n` out 1 — CPU reset, active-low
- `cpu_enable` out 1
- `addr_ext` out 64, `wen_ext` out 1, `ren_ext` out 1, `wdata_ext` out 32, `rdata_ext` in 32
- `addr_ext_2` out 64, `wen_ext_2` out 1, `ren_ext_2` out 1, `wdata_ext_2` out 64, `rdata_ext_2` in 64

## Operation
- States: IDLE, RST, RUN, DONE. Reset enters IDLE.
- IDLE/DONE + `start` → RST. Latch `cycle_limit`. Clear `cycles`.
- RST lasts one cycle with `cpu_arst_n`=0, then goes to RUN.
- RUN exits to DONE on `stop`, or on the enabled cycle where `cycles`+1 == latched limit (limit ≠ 0). Exactly `limit` enabled cycles occur. `stop` together with the limit → DONE, same result.
- In RUN, `start` is ignored. In other states, `stop` is ignored.
- `cpu_enable`=1 exactly in RUN.
- `cpu_arst_n`=0 in IDLE and RST; 1 in RUN and DONE, so DONE preserves CPU state.
- `cycles` increments on every RUN cycle and saturates at all-ones.
- Accesses only in IDLE and DONE: `acc_ready` = (IDLE|DONE) & !rd_pending & !`start`. `start` wins over a simultaneous access.
- Write beat: in the cycle after the handshake, drive selected `wen_ext*`=1 with address/data for one cycle. No response. One write per cycle sustained.
- Read beat: next cycle drive selected `ren_ext*`=1 and set rd_pending. The cycle after that, `rsp_valid`=1 for one cycle with captured `rdata_ext*`. One read per 3 cycles max. `rsp_valid` is not back-pressured.
- Unselected port: wen/ren=0, address and data held at 0.

## Timing
- All outputs registered. Reset values: `cpu_arst_n`=0, `cpu_enable`=0, `busy`=0, `done`=0, `cycles`=0, `acc_ready`=0 for the first cycle after reset release, all ext strobes/addresses/data 0, `rsp_valid`=0, `rsp_data`=0.
- `start` at edge n → RST at n+1, first `cpu_enable`=1 at n+2.
- `stop` at edge m → `cpu_enable`=0 and `done`=1 from m+1.
- Memory read latency is 1 cycle after `ren_ext*`. Handshake to `rsp_valid` is 3 edges.
- `arst` mid-operation returns to IDLE immediately. An in-flight read is dropped: no `rsp_valid`. Memory contents are untouched.

## Configuration
- `CPU_RUN_CYCLE_LIMIT_EN` defined: cycle-limit termination as above.
- Not defined: `cycle_limit` is ignored; RUN ends only on `stop`. `cycles` is still counted.

## Test plan
- Load 4 imem words at 0,4,8,12 and 2 dmem words, then read all back → each `rsp_data` matches; `wen_ext` pulses exactly 4 cycles.
- `start` with `cycle_limit`=10 → `cpu_enable` high exactly 10 cycles, `done`=1, `cycles`=10; one `cpu_arst_n`=0 cycle before the run.
- `start` with limit 0, `stop` after 25 enabled cycles → `cycles`=25, DONE. Second `start` from DONE → RST, counter cleared.
- `start` and `acc_valid` in the same IDLE cycle → `acc_ready`=0, no memory strobe, run begins; access accepted after DONE.
- `arst` asserted during RUN and during a pending read → IDLE, `cpu_enable`=0, no `rsp_valid`.
- Limit with `cycle_limit`=3 and `stop` in cycle 3 → single DONE entry, `cycles`=3. Without the macro, limit 3 ignored and run continues until `stop`.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller sequencing host load, cpu reset, bounded run, halt and readback
//
// Purpose:
//   Sits directly above the pipelined RISC-V cpu and is the only driver of its
//   enable, its reset and both external memory ports. The host loads and reads
//   memory through one valid/ready access channel while the cpu is stopped, and
//   starts/stops runs through start/stop.
//
// Optional feature macro:
//   CPU_RUN_CYCLE_LIMIT_EN - when defined, RUN also ends after cycle_limit
//   enabled cycles (0 = unlimited). When undefined cycle_limit is ignored.
//
// Ports:
//   clk, arst              clock, asynchronous active-high reset
//   start                  run request, taken in IDLE or DONE
//   stop                   halt request, taken in RUN
//   cycle_limit            enabled-cycle budget, latched when start is taken
//   busy, done             status: busy in RST/RUN, done in DONE
//   cycles                 saturating count of enabled cycles of current/last run
//   acc_valid, acc_ready   host access handshake
//   acc_write, acc_sel     1 = write / 0 = read; 0 = imem / 1 = dmem
//   acc_addr, acc_wdata    access address and write data (imem uses [31:0])
//   rsp_valid, rsp_data    one-cycle read response, imem zero-extended
//   cpu_arst_n, cpu_enable cpu reset (active-low) and clock enable
//   *_ext                  instruction memory port, 32-bit data
//   *_ext_2                data memory port, 64-bit data

module cpu_run_ctrl #(
   parameter int CYC_W = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic             stop,
   input  logic [CYC_W-1:0] cycle_limit,
   output logic             busy,
   output logic             done,
   output logic [CYC_W-1:0] cycles,
   input  logic             acc_valid,
   output logic             acc_ready,
   input  logic             acc_write,
   input  logic             acc_sel,
   input  logic [63:0]      acc_addr,
   input  logic [63:0]      acc_wdata,
   output logic             rsp_valid,
   output logic [63:0]      rsp_data,
   output logic             cpu_arst_n,
   output logic             cpu_enable,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   input  logic [31:0]      rdata_ext,
   output logic [63:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [63:0]      wdata_ext_2,
   input  logic [63:0]      rdata_ext_2
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RST  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic             acc_ready_q;
   logic             rd_issue_q;    // ren cycle of a read in flight
   logic             rd_capture_q;  // memory data valid, captured at the end of this cycle
   logic             rd_sel_q;      // port of the read in flight
   logic             host_state;
   logic             start_take;
   logic             acc_fire;
   logic             wr_fire;
   logic             rd_fire;
   logic             host_state_d;
   logic             acc_ready_d;
   logic             limit_hit;
   logic [CYC_W-1:0] cycles_nx;

   assign host_state = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign start_take = start & host_state;

   // acc_ready is registered except for the start gate: a start presented in
   // the same cycle as an access must win, so the access is never accepted.
   assign acc_ready = acc_ready_q & ~start;
   assign acc_fire  = acc_valid & acc_ready;
   assign wr_fire   = acc_fire & acc_write;
   assign rd_fire   = acc_fire & ~acc_write;

   assign cycles_nx = (&cycles) ? cycles : cycles + CYC_ONE;

`ifdef CPU_RUN_CYCLE_LIMIT_EN
   logic [CYC_W-1:0] limit_q;

   // Hit on the enabled cycle that brings the count to the limit, so exactly
   // limit enabled cycles run.
   assign limit_hit = (limit_q != '0) && (cycles_nx == limit_q);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         limit_q <= '0;
      end else if (start_take) begin
         limit_q <= cycle_limit;
      end
   end
`else
   logic unused_cycle_limit;

   assign unused_cycle_limit = ^cycle_limit;
   assign limit_hit          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RST;
         ST_RST:  state_d = ST_RUN;
         ST_RUN:  if (stop || limit_hit) state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_RST;
         default: state_d = ST_IDLE;
      endcase
   end

   // Ready for the next cycle: host-accessible state and no read will be in
   // flight (a read occupies its ren cycle and its data cycle).
   assign host_state_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
   assign acc_ready_d  = host_state_d & ~rd_fire & ~rd_issue_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= ST_IDLE;
         acc_ready_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cpu_enable  <= 1'b0;
         cpu_arst_n  <= 1'b0;
         cycles      <= '0;
      end else begin
         state_q     <= state_d;
         acc_ready_q <= acc_ready_d;
         busy        <= (state_d == ST_RST) || (state_d == ST_RUN);
         done        <= (state_d == ST_DONE);
         cpu_enable  <= (state_d == ST_RUN);
         // cpu stays out of reset in DONE so its state can be inspected.
         cpu_arst_n  <= (state_d == ST_RUN) || (state_d == ST_DONE);
         if (start_take) begin
            cycles <= '0;
         end else if (state_q == ST_RUN) begin
            cycles <= cycles_nx;
         end
      end
   end

   // Memory beats: every strobe, address and data lane defaults to zero, so
   // the unselected port and idle cycles always present zeros.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wen_ext     <= 1'b0;
         ren_ext     <= 1'b0;
         addr_ext    <= '0;
         wdata_ext   <= '0;
         wen_ext_2   <= 1'b0;
         ren_ext_2   <= 1'b0;
         addr_ext_2  <= '0;
         wdata_ext_2 <= '0;
      end else begin
         wen_ext     <= wr_fire & ~acc_sel;
         ren_ext     <= rd_fire & ~acc_sel;
         addr_ext    <= (acc_fire & ~acc_sel) ? acc_addr : '0;
         wdata_ext   <= (wr_fire & ~acc_sel) ? acc_wdata[31:0] : '0;
         wen_ext_2   <= wr_fire & acc_sel;
         ren_ext_2   <= rd_fire & acc_sel;
         addr_ext_2  <= (acc_fire & acc_sel) ? acc_addr : '0;
         wdata_ext_2 <= (wr_fire & acc_sel) ? acc_wdata : '0;
      end
   end

   // Read pipeline: handshake -> ren cycle -> data cycle -> rsp_valid.
   // Reset clears the pipeline, so an in-flight read never responds.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rd_issue_q   <= 1'b0;
         rd_capture_q <= 1'b0;
         rd_sel_q     <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
      end else begin
         rd_issue_q   <= rd_fire;
         rd_capture_q <= rd_issue_q;
         if (rd_fire) begin
            rd_sel_q <= acc_sel;
         end
         rsp_valid <= rd_capture_q;
         if (rd_capture_q) begin
            rsp_data <= rd_sel_q ? rdata_ext_2 : {32'd0, rdata_ext};
         end
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl with randomized access and run stimulus

module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        arst;
   logic        start;
   logic        stop;
   logic [31:0] cycle_limit;
   logic        busy;
   logic        done;
   logic [31:0] cycles;
   logic        acc_valid;
   logic        acc_ready;
   logic        acc_write;
   logic        acc_sel;
   logic [63:0] acc_addr;
   logic [63:0] acc_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_data;
   logic        cpu_arst_n;
   logic        cpu_enable;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] rdata_ext = 32'd0;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic [63:0] rdata_ext_2 = 64'd0;

   localparam logic [63:0] DBASE = 64'h8000_0000_0000_0100;

   cpu_run_ctrl #(.CYC_W(32)) dut (
      .clk(clk), .arst(arst), .start(start), .stop(stop), .cycle_limit(cycle_limit),
      .busy(busy), .done(done), .cycles(cycles),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_write(acc_write), .acc_sel(acc_sel),
      .acc_addr(acc_addr), .acc_wdata(acc_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .rdata_ext(rdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   // External memories (environment): synchronous read, one cycle after ren.
   logic [31:0] env_imem [logic [63:0]];
   logic [63:0] env_dmem [logic [63:0]];

   always @(posedge clk) begin
      if (wen_ext)   env_imem[addr_ext] = wdata_ext;
      if (wen_ext_2) env_dmem[addr_ext_2] = wdata_ext_2;
      if (ren_ext)   rdata_ext <= env_imem.exists(addr_ext) ? env_imem[addr_ext] : 32'd0;
      if (ren_ext_2) rdata_ext_2 <= env_dmem.exists(addr_ext_2) ? env_dmem[addr_ext_2] : 64'd0;
   end

   // Reference model: what the host believes memory holds.
   logic [31:0] ref_imem [logic [63:0]];
   logic [63:0] ref_dmem [logic [63:0]];

   function automatic logic [63:0] ref_read(input bit sel, input logic [63:0] a);
      if (sel) return ref_dmem.exists(a) ? ref_dmem[a] : 64'd0;
      return {32'd0, ref_imem.exists(a) ? ref_imem[a] : 32'd0};
   endfunction

   typedef struct { bit sel; logic [63:0] addr; logic [63:0] data; int due; } wexp_t;
   typedef struct { logic [63:0] data; int due; } rexp_t;

   wexp_t wq[$];
   rexp_t rq[$];

   int en_cnt = 0, rst_cnt = 0, wen_i_cnt = 0, wen_d_cnt = 0, rsp_cnt = 0, viol = 0;

   // Monitor: pops expectations whenever the DUT presents a write beat or a response.
   always @(negedge clk) begin : monitor
      wexp_t w;
      rexp_t r;
      if (!arst) begin
         if (cpu_enable) en_cnt++;
         if (!cpu_arst_n && busy) rst_cnt++;
         if (wen_ext) wen_i_cnt++;
         if (wen_ext_2) wen_d_cnt++;
         if (rsp_valid) rsp_cnt++;
         if (!wen_ext && !ren_ext && (addr_ext != 0 || wdata_ext != 0)) viol++;
         if (!wen_ext_2 && !ren_ext_2 && (addr_ext_2 != 0 || wdata_ext_2 != 0)) viol++;
         if ((ren_ext && wdata_ext != 0) || (ren_ext_2 && wdata_ext_2 != 0)) viol++;
         if ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) viol++;
         if (cpu_enable && !(busy && cpu_arst_n)) viol++;
         if (done && (busy || !cpu_arst_n || cpu_enable)) viol++;
         if (acc_ready && busy) viol++;
         if (busy && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) viol++;
         if (wen_ext || wen_ext_2) begin
            chk("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
               w = wq.pop_front();
               chk("wr_port", 64'(wen_ext_2), 64'(w.sel));
               chk("wr_addr", w.sel ? addr_ext_2 : addr_ext, w.addr);
               chk("wr_data", w.sel ? wdata_ext_2 : 64'(wdata_ext), w.data);
               chk("wr_cycle", 64'(cyc), 64'(w.due));
            end
         end
         if (rsp_valid) begin
            chk("rsp_expected", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
               r = rq.pop_front();
               chk("rsp_data", rsp_data, r.data);
               chk("rsp_latency", 64'(cyc), 64'(r.due));
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic access(input bit wr, input bit sel, input logic [63:0] addr, input logic [63:0] wd);
      wexp_t w;
      rexp_t r;
      bit ok = 1'b0;
      acc_valid = 1'b1; acc_write = wr; acc_sel = sel; acc_addr = addr; acc_wdata = wd;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = acc_ready;
         @(posedge clk);
         #1;
      end
      acc_valid = 1'b0;
      chk("acc_handshake", 64'(ok), 64'd1);
      if (ok) begin
         if (wr) begin
            if (sel) ref_dmem[addr] = wd;
            else ref_imem[addr] = wd[31:0];
            w.sel = sel; w.addr = addr; w.data = sel ? wd : {32'd0, wd[31:0]}; w.due = cyc;
            wq.push_back(w);
         end else begin
            r.data = ref_read(sel, addr); r.due = cyc + 2;
            rq.push_back(r);
         end
      end
   endtask

   function automatic logic [63:0] pool_addr(input bit sel);
      logic [63:0] idx = 64'($urandom_range(0, 7));
      return sel ? DBASE + (idx << 3) : (idx << 2);
   endfunction

   task automatic run(input int lim, input int stop_at, input bit poke_start, input bit with_acc);
      int  exp_n = stop_at;
      int  k = 0;
      bit  fin = 1'b0;
`ifdef CPU_RUN_CYCLE_LIMIT_EN
      if (lim != 0 && lim <= stop_at) exp_n = lim;
`endif
      en_cnt = 0; rst_cnt = 0;
      cycle_limit = lim; start = 1'b1;
      if (with_acc) begin
         acc_valid = 1'b1; acc_write = 1'b1; acc_sel = 1'($urandom_range(0, 1));
         acc_addr = pool_addr(acc_sel); acc_wdata = {$urandom, $urandom};
      end
      @(negedge clk);
      chk("start_gates_ready", 64'(acc_ready), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0; acc_valid = 1'b0; cycle_limit = $urandom;
      chk("rst_arst_n", 64'(cpu_arst_n), 64'd0);
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_enable", 64'(cpu_enable), 64'd0);
      chk("rst_cycles_clear", 64'(cycles), 64'd0);
      for (int t = 0; t < 500 && !fin; t++) begin
         @(posedge clk);
         #1;
         stop = 1'b0; start = 1'b0;
         if (done) fin = 1'b1;
         else if (cpu_enable) begin
            k++;
            if (k == stop_at) stop = 1'b1;
            if (poke_start && k == 2) start = 1'b1;
         end
      end
      stop = 1'b0; start = 1'b0;
      chk("run_reached_done", 64'(fin), 64'd1);
      chk("run_busy", 64'(busy), 64'd0);
      chk("run_enable_off", 64'(cpu_enable), 64'd0);
      chk("run_arst_n_kept", 64'(cpu_arst_n), 64'd1);
      chk("run_cycles", 64'(cycles), 64'(exp_n));
      chk("run_enabled_cycles", 64'(en_cnt), 64'(exp_n));
      chk("run_reset_cycles", 64'(rst_cnt), 64'd1);
      chk("run_ready_in_done", 64'(acc_ready), 64'd1);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      chk("stop_ignored_done", 64'(done), 64'd1);
      chk("stop_ignored_cycles", 64'(cycles), 64'(exp_n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int rsp_before;
      logic [31:0] iw [4];
      arst = 1'b1; start = 1'b0; stop = 1'b0; cycle_limit = '0;
      acc_valid = 1'b0; acc_write = 1'b0; acc_sel = 1'b0; acc_addr = '0; acc_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_arst_n", 64'(cpu_arst_n), 64'd0);
      chk("reset_enable", 64'(cpu_enable), 64'd0);
      chk("reset_busy_done", 64'({busy, done}), 64'd0);
      chk("reset_cycles", 64'(cycles), 64'd0);
      chk("reset_ready", 64'(acc_ready), 64'd0);
      chk("reset_rsp", 64'({rsp_valid, rsp_data}), 64'd0);
      chk("reset_strobes", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
      chk("reset_ext", addr_ext | addr_ext_2 | wdata_ext_2 | 64'(wdata_ext), 64'd0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      chk("ready_first_cycle", 64'(acc_ready), 64'd0);
      idle(1);
      chk("ready_after_first", 64'(acc_ready), 64'd1);

      stop = 1'b1;
      idle(1);
      stop = 1'b0;
      chk("stop_ignored_idle", 64'({busy, done, cpu_enable}), 64'd0);

      // Directed load and readback.
      for (int i = 0; i < 4; i++) begin
         iw[i] = $urandom;
         access(1'b1, 1'b0, 64'(i * 4), {$urandom, iw[i]});
      end
      access(1'b1, 1'b1, DBASE, {$urandom, $urandom});
      access(1'b1, 1'b1, DBASE + 64'd8, {$urandom, $urandom});
      idle(2);
      chk("imem_wen_pulses", 64'(wen_i_cnt), 64'd4);
      chk("dmem_wen_pulses", 64'(wen_d_cnt), 64'd2);
      for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 64'(i * 4), 64'd0);
      access(1'b0, 1'b1, DBASE, 64'd0);
      access(1'b0, 1'b1, DBASE + 64'd8, 64'd0);
      idle(4);

      // Random traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         bit wr = 1'($urandom_range(0, 1));
         bit sel = 1'($urandom_range(0, 1));
         access(wr, sel, pool_addr(sel), {$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);

      // Runs.
      run(10, 40, 1'b0, 1'b0);
      run(0, 25, 1'b1, 1'b0);
      run(3, 3, 1'b0, 1'b0);
      run(3, 8, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 64'(i * 4), 64'd0);
      idle(4);
      for (int i = 0; i < 6; i++) begin
         bit sel = 1'($urandom_range(0, 1));
         run($urandom_range(0, 20), $urandom_range(1, 30), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
         access(1'b1, sel, pool_addr(sel), {$urandom, $urandom});
         access(1'b0, sel, pool_addr(sel), 64'd0);
         idle(4);
      end

      // Reset during RUN.
      cycle_limit = '0; start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(6);
      chk("pre_arst_enable", 64'(cpu_enable), 64'd1);
      arst = 1'b1;
      #1;
      chk("arst_run_enable", 64'(cpu_enable), 64'd0);
      chk("arst_run_state", 64'({busy, done, cpu_arst_n}), 64'd0);
      chk("arst_run_cycles", 64'(cycles), 64'd0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      chk("arst_ready_first", 64'(acc_ready), 64'd0);
      idle(1);
      chk("arst_ready_after", 64'(acc_ready), 64'd1);

      // Reset during a pending read.
      rsp_before = rsp_cnt;
      acc_valid = 1'b1; acc_write = 1'b0; acc_sel = 1'b1; acc_addr = DBASE;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = acc_ready;
         @(posedge clk);
         #1;
      end
      acc_valid = 1'b0;
      chk("pend_handshake", 64'(ok), 64'd1);
      chk("pend_ren", 64'(ren_ext_2), 64'd1);
      arst = 1'b1;
      #1;
      chk("pend_ren_cleared", 64'(ren_ext_2), 64'd0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      idle(5);
      chk("pend_no_rsp", 64'(rsp_cnt - rsp_before), 64'd0);

      // Memory contents survive reset.
      access(1'b0, 1'b1, DBASE, 64'd0);
      access(1'b0, 1'b1, DBASE + 64'd8, 64'd0);
      access(1'b0, 1'b0, 64'd0, 64'd0);
      idle(5);

      chk("wq_drained", 64'(wq.size()), 64'd0);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("invariant_violations", 64'(viol), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
